// File: rtl/stateful_alu_rmw.sv
// Pipelined stateful action ALU with an internal key-value RAM, atomic RMW/swap and RAW forwarding.
// Optional: define STATEFUL_ALU_SAT_EN to saturate add/sub/fetch-add instead of wrapping.
module stateful_alu_rmw #(
  parameter int STAGE_ID   = 0,
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ACTION_LEN-1:0] action_in,
  input  logic                  action_valid,
  input  logic [DATA_WIDTH-1:0] operand_1_in,
  input  logic [DATA_WIDTH-1:0] operand_2_in,
  input  logic [DATA_WIDTH-1:0] operand_3_in,
  output logic [DATA_WIDTH-1:0] container_out,
  output logic                  container_out_valid,
  output logic                  addr_err
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0001,
    OP_SUB   = 4'b0010,
    OP_STORE = 4'b1000,
    OP_ADDI  = 4'b1001,
    OP_SUBI  = 4'b1010,
    OP_LOAD  = 4'b1011,
    OP_FADD  = 4'b1100,
    OP_SWAP  = 4'b1101
  } opcode_e;

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  s1_valid, s2_valid;
  logic [3:0]            s1_op, s2_op;
  logic [DATA_WIDTH-1:0] s1_op1, s1_op2, s1_op3;
  logic [DATA_WIDTH-1:0] s2_op1, s2_op2, s2_op3, s2_rdata;
  logic                  s1_oob, s2_oob;
  logic [ADDR_WIDTH-1:0] s1_addr, s2_addr;
  logic [IDX_W-1:0]      s1_idx, s2_idx;

  logic [DATA_WIDTH-1:0] add_res, sub_res, fadd_res, result, wr_data;
  logic                  wr_en, is_write, ram_op;
  logic                  unused_bits;

  assign unused_bits = ^{action_in[ACTION_LEN-5:0], 32'(STAGE_ID)};

  assign s1_addr = s1_op2[ADDR_WIDTH-1:0];
  assign s2_addr = s2_op2[ADDR_WIDTH-1:0];
  assign s1_idx  = s1_addr[IDX_W-1:0];
  assign s2_idx  = s2_addr[IDX_W-1:0];
  // Constant-false when the address space exactly matches the RAM depth.
  assign s1_oob  = {1'b0, s1_addr} >= DEPTH_W;

`ifdef STATEFUL_ALU_SAT_EN
  logic [DATA_WIDTH:0] add_full, sub_full, fadd_full;
  assign add_full  = {1'b0, s2_op1} + {1'b0, s2_op2};
  assign sub_full  = {1'b0, s2_op1} - {1'b0, s2_op2};
  assign fadd_full = {1'b0, s2_rdata} + {1'b0, s2_op1};
  assign add_res   = add_full[DATA_WIDTH]  ? {DATA_WIDTH{1'b1}} : add_full[DATA_WIDTH-1:0];
  assign sub_res   = sub_full[DATA_WIDTH]  ? '0                 : sub_full[DATA_WIDTH-1:0];
  assign fadd_res  = fadd_full[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : fadd_full[DATA_WIDTH-1:0];
`else
  assign add_res  = s2_op1 + s2_op2;
  assign sub_res  = s2_op1 - s2_op2;
  assign fadd_res = s2_rdata + s2_op1;
`endif

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    result   = s2_op3;
    wr_data  = s2_op1;
    is_write = 1'b0;
    ram_op   = 1'b0;
    case (s2_op)
      OP_ADD, OP_ADDI: result = add_res;
      OP_SUB, OP_SUBI: result = sub_res;
      OP_STORE: begin
        is_write = 1'b1;
        ram_op   = 1'b1;
      end
      OP_LOAD: begin
        result = s2_rdata;
        ram_op = 1'b1;
      end
      OP_FADD: begin
        result   = fadd_res;
        wr_data  = fadd_res;
        is_write = 1'b1;
        ram_op   = 1'b1;
      end
      OP_SWAP: begin
        result   = s2_rdata;
        is_write = 1'b1;
        ram_op   = 1'b1;
      end
      default: result = s2_op3;
    endcase
  end

  assign wr_en = s2_valid && is_write && !s2_oob;

  // NOTE: RAM and datapath registers are not reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    s1_op  <= action_in[ACTION_LEN-1 -: 4];
    s1_op1 <= operand_1_in;
    s1_op2 <= operand_2_in;
    s1_op3 <= operand_3_in;

    s2_op  <= s1_op;
    s2_op1 <= s1_op1;
    s2_op2 <= s1_op2;
    s2_op3 <= s1_op3;
    s2_oob <= s1_oob;

    // Write-first bypass: the action one slot ahead commits on this same edge.
    if (s1_oob)
      s2_rdata <= '0;
    else if (wr_en && (s2_addr == s1_addr))
      s2_rdata <= wr_data;
    else
      s2_rdata <= mem[s1_idx];

    if (wr_en)
      mem[s2_idx] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all stages advance together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid            <= 1'b0;
      s2_valid            <= 1'b0;
      container_out_valid <= 1'b0;
      addr_err            <= 1'b0;
      container_out       <= '0;
    end else begin
      s1_valid            <= action_valid;
      s2_valid            <= s1_valid;
      container_out_valid <= s2_valid;
      addr_err            <= s2_valid && s2_oob && ram_op;
      if (s2_valid)
        container_out <= result;
    end
  end

endmodule

// File: tb/tb_stateful_alu_rmw.sv
// Self-checking bench for stateful_alu_rmw: vector table, RMW/forwarding sequences, out-of-range and reset cases.
// Expected results are queued at issue time with their due cycle and checked as outputs appear.
module tb_stateful_alu_rmw;

`ifdef STATEFUL_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [3:0] ADD = 4'b0001, SUB = 4'b0010, STORE = 4'b1000, ADDI = 4'b1001,
                         SUBI = 4'b1010, LOAD = 4'b1011, FADD = 4'b1100, SWAP = 4'b1101;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
    string       tag;
  } exp_t;

  typedef struct {
    logic [3:0]  opc;
    logic [31:0] o1, o2, o3, exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [24:0] action = '0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic [31:0] op1 = '0, op2 = '0, op3 = '0;
  logic [31:0] out_a, out_b;
  logic        out_valid_a, out_valid_b, err_a, err_b;

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  vec_t vecs[9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stateful_alu_rmw dut_a (
    .clk(clk), .rst_n(rst_n), .action_in(action), .action_valid(valid_a),
    .operand_1_in(op1), .operand_2_in(op2), .operand_3_in(op3),
    .container_out(out_a), .container_out_valid(out_valid_a), .addr_err(err_a)
  );

  stateful_alu_rmw #(.MEM_DEPTH(20), .ADDR_WIDTH(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .action_in(action), .action_valid(valid_b),
    .operand_1_in(op1), .operand_2_in(op2), .operand_3_in(op3),
    .container_out(out_b), .container_out_valid(out_valid_b), .addr_err(err_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one action for a single edge; optionally queue its expected result.
  task automatic issue(input bit sel_b, input logic [3:0] opc, input logic [31:0] o1, input logic [31:0] o2,
                       input logic [31:0] o3, input logic [31:0] exp_d, input logic exp_e,
                       input string tag, input bit track = 1'b1);
    exp_t e;
    action = {opc, 21'($urandom)};
    op1 = o1;
    op2 = o2;
    op3 = o3;
    valid_a = !sel_b;
    valid_b = sel_b;
    @(posedge clk);
    #1;
    if (track) begin
      e.data = exp_d;
      e.err  = exp_e;
      e.due  = cyc + 2;
      e.tag  = tag;
      if (sel_b) q_b.push_back(e);
      else q_a.push_back(e);
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (q_a.size() > 0 && q_a[0].due == cyc) begin
        e = q_a.pop_front();
        check({e.tag, " valid"}, 32'(out_valid_a), 32'd1);
        check({e.tag, " data"}, out_a, e.data);
        check({e.tag, " addr_err"}, 32'(err_a), 32'(e.err));
      end else if (out_valid_a) begin
        check("a unexpected valid", 32'(out_valid_a), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (q_b.size() > 0 && q_b[0].due == cyc) begin
        e = q_b.pop_front();
        check({e.tag, " valid"}, 32'(out_valid_b), 32'd1);
        check({e.tag, " data"}, out_b, e.data);
        check({e.tag, " addr_err"}, 32'(err_b), 32'(e.err));
      end else if (out_valid_b) begin
        check("b unexpected valid", 32'(out_valid_b), 32'd0);
      end
    end
  end

  initial begin
    vecs[0] = '{ADD,       32'hFFFF_FFFF, 32'h2,         32'h0,         SAT ? 32'hFFFF_FFFF : 32'h1};
    vecs[1] = '{SUB,       32'h1,         32'h2,         32'h0,         SAT ? 32'h0 : 32'hFFFF_FFFF};
    vecs[2] = '{ADDI,      32'h3,         32'h4,         32'h0,         32'h7};
    vecs[3] = '{SUBI,      32'hA,         32'h3,         32'h0,         32'h7};
    vecs[4] = '{ADD,       32'h1234_0000, 32'h0000_5678, 32'h0,         32'h1234_5678};
    vecs[5] = '{SUB,       32'h100,       32'h1,         32'h0,         32'hFF};
    vecs[6] = '{4'b0000,   32'h1,         32'h1,         32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[7] = '{4'b0111,   32'h5,         32'h3,         32'h0BAD_BEEF, 32'h0BAD_BEEF};
    vecs[8] = '{4'b1111,   32'h9,         32'h1F,        32'h1357_9BDF, 32'h1357_9BDF};

    // Reset state
    idle(2);
    check("reset container_out", out_a, 32'h0);
    check("reset container_out_valid", 32'(out_valid_a), 32'h0);
    check("reset addr_err", 32'(err_a), 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Store then load with one idle slot
    issue(0, STORE, 32'hAA, 32'd3, 32'h55, 32'h55, 0, "store a3");
    idle(1);
    issue(0, LOAD, 32'h0, 32'd3, 32'h0, 32'hAA, 0, "load a3");
    idle(1);

    // Back-to-back fetch-add on one address
    issue(0, STORE, 32'd10, 32'd7, 32'h0, 32'h0, 0, "store a7");
    idle(3);
    for (int i = 0; i < 4; i++)
      issue(0, FADD, 32'd1, 32'd7, 32'h0, 32'(11 + i), 0, $sformatf("fadd a7 #%0d", i));
    issue(0, LOAD, 32'h0, 32'd7, 32'h0, 32'd14, 0, "load a7 after fadd");
    // One-gap forwarding
    issue(0, FADD, 32'd1, 32'd7, 32'h0, 32'd15, 0, "fadd a7 gap");
    idle(1);
    issue(0, LOAD, 32'h0, 32'd7, 32'h0, 32'd15, 0, "load a7 gap");
    idle(1);

    // Swap then immediate load
    issue(0, STORE, 32'd5, 32'd0, 32'h0, 32'h0, 0, "store a0");
    idle(3);
    issue(0, SWAP, 32'd9, 32'd0, 32'h0, 32'd5, 0, "swap a0");
    issue(0, LOAD, 32'h0, 32'd0, 32'h0, 32'd9, 0, "load a0 after swap");
    idle(1);

    // Pure-ALU and pass-through table, issued back to back
    for (int i = 0; i < 9; i++)
      issue(0, vecs[i].opc, vecs[i].o1, vecs[i].o2, vecs[i].o3, vecs[i].exp, 0, $sformatf("vec %0d", i));
    idle(3);

    // Non-power-of-two depth: addresses 20..31 are out of range
    issue(1, STORE, 32'h77, 32'd5, 32'hA, 32'hA, 0, "b store 5");
    issue(1, STORE, 32'h19, 32'd19, 32'hB, 32'hB, 0, "b store 19");
    issue(1, STORE, 32'hDEAD, 32'd25, 32'h11, 32'h11, 1, "b store 25");
    issue(1, LOAD, 32'h0, 32'd25, 32'h0, 32'h0, 1, "b load 25");
    issue(1, SWAP, 32'h1, 32'd20, 32'h0, 32'h0, 1, "b swap 20");
    issue(1, ADD, 32'h1, 32'd25, 32'h0, 32'd26, 0, "b add op2=25");
    issue(1, LOAD, 32'h0, 32'd19, 32'h0, 32'h19, 0, "b load 19");
    issue(1, LOAD, 32'h0, 32'd5, 32'h0, 32'h77, 0, "b load 5");
    idle(3);

    // Reset with two actions in flight, one a pending store
    issue(0, STORE, 32'h33, 32'd9, 32'h1, 32'h1, 0, "store a9");
    idle(3);
    issue(0, STORE, 32'h44, 32'd9, 32'h2, 32'h0, 0, "dropped store", 1'b0);
    issue(0, ADD, 32'h1, 32'h1, 32'h0, 32'h0, 0, "dropped add", 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid reset container_out", out_a, 32'h0);
    check("mid reset container_out_valid", 32'(out_valid_a), 32'h0);
    idle(1);
    rst_n = 1'b1;
    idle(3);
    issue(0, LOAD, 32'h0, 32'd9, 32'h0, 32'h33, 0, "load a9 after reset");

    for (int i = 0; i < 30 && (q_a.size() > 0 || q_b.size() > 0); i++)
      @(posedge clk);
    idle(1);
    check("dut_a outstanding results", 32'(q_a.size()), 32'd0);
    check("dut_b outstanding results", 32'(q_b.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
